iir_m_feeder: RTL and testbench
===============================

IIR_M_FEEDER -- requirements
Module: iir_m_feeder

Interface
REQ-001 Parameter DEPTH, default 8, sets sample FIFO depth (power of 2, 2..64).
REQ-002 Parameter TIMEOUT, default 15, sets the maximum cycles from issue to filter completion.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-low.
REQ-005 s_data  input  18  signed upstream sample.
REQ-006 s_valid  input  1  upstream sample present.
REQ-007 s_ready  output  1  feeder can accept a sample; high when FIFO not full.
REQ-008 f_din  output  18  signed sample driven to the biquad filter din.
REQ-009 f_din_valid  output  1  one-cycle start pulse to the filter din_valid.
REQ-010 f_dout_valid  input  1  filter completion pulse (filter dout_valid).
REQ-011 fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-012 busy  output  1  high while a sample is in flight in the filter.
REQ-013 timeout_err  output  1  sticky; the filter failed to complete within TIMEOUT.

Function
REQ-014 A push occurs on a cycle with s_valid && s_ready; a push writes s_data into the FIFO tail.
REQ-015 Controller FSM states: IDLE, ISSUE, WAIT_DONE.
REQ-016 IDLE with FIFO non-empty: pop the head into the f_din register, then go to ISSUE next cycle.
REQ-017 IDLE with FIFO empty: stay in IDLE; f_din holds its last value.
REQ-018 ISSUE: f_din_valid=1 for exactly this one cycle, then go to WAIT_DONE.
REQ-019 WAIT_DONE: f_din stable and f_din_valid=0; the filter samples din up to 6 cycles after the pulse.
REQ-020 WAIT_DONE with f_dout_valid=1 and FIFO non-empty: pop the next sample, then go to ISSUE (back-to-back).
REQ-021 WAIT_DONE with f_dout_valid=1 and FIFO empty: go to IDLE.
REQ-022 Back-to-back throughput: ISSUE cycles are exactly 7 cycles apart (issue at t, f_dout_valid at t+6, next issue at t+7).
REQ-023 f_dout_valid outside WAIT_DONE is ignored.
REQ-024 busy = (state != IDLE).
REQ-025 No bypass: a sample pushed into an empty FIFO is popped no earlier than the next cycle, so the earliest ISSUE is push cycle +2.
REQ-026 A push and a pop in the same cycle leave fifo_level unchanged.
REQ-027 Read and write pointers wrap modulo DEPTH.
REQ-028 When full, s_ready=0 and s_valid is ignored; no overwrite occurs.
REQ-029 Data passes through unmodified: 18-bit two's complement, no scaling or saturation.

Reset
REQ-030 When rst=0 at a clock edge: FSM=IDLE, FIFO empty, fifo_level=0, f_din=0, f_din_valid=0, busy=0, timeout_err=0, timeout counter=0.
REQ-031 Reset during WAIT_DONE discards the in-flight sample, and a later f_dout_valid is ignored.
REQ-032 s_ready=0 while rst=0.

Configuration
REQ-033 Macro IIR_M_FEEDER_TIMEOUT_EN defined: a counter clears on ISSUE and counts in WAIT_DONE.
REQ-034 With the macro, if the counter reaches TIMEOUT without f_dout_valid: set timeout_err, go to IDLE, and drop the in-flight sample.
REQ-035 Macro undefined: no counter exists, WAIT_DONE waits indefinitely, and timeout_err is tied to 0.

Structure
REQ-036 Shared package iir_m_pkg holds SAMPLE_W=18, the FSM state enum type, and FILTER_LATENCY=7.
REQ-037 The FIFO is a sub-module iir_m_sync_fifo (synchronous, registered read, push/pop/full/empty/level); the FSM and timeout logic stay in iir_m_feeder.

Verification
REQ-038 Reset, then push 100 -> ISSUE 2 cycles after the push; f_din_valid=1 for one cycle; f_din=100 held stable until f_dout_valid.
REQ-039 Push 5 samples (1..5) with the filter model answering at +6 -> issues exactly 7 cycles apart; values 1..5 in order; fifo_level returns to 0.
REQ-040 Push 8 samples with the filter stalled -> s_ready=0 at level 8; the 9th s_valid is ignored; after release the drained order is unchanged.
REQ-041 Macro defined, TIMEOUT=15, no f_dout_valid -> timeout_err=1 exactly 15 cycles after ISSUE; FSM in IDLE; the next sample issues normally.
REQ-042 Assert rst=0 mid WAIT_DONE with 3 samples queued -> all outputs zero next cycle; a stray f_dout_valid afterwards causes no ISSUE.
REQ-043 Push -32768 and 131071 -> f_din carries the same values bit-exactly, with no sign or width change.

Source files
------------

// File: rtl/iir_m_pkg.sv
// Shared definitions for the biquad sample feeder: sample width, controller states, filter turnaround.
package iir_m_pkg;
    localparam int SAMPLE_W       = 18;
    localparam int FILTER_LATENCY = 7;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/iir_m_sync_fifo.sv
// Synchronous sample FIFO with registered read data: a pop loads the head into o_rd_dat at the clock edge.
// Push is ignored while full and pop is ignored while empty; pointers wrap modulo DEPTH (power of two).
module iir_m_sync_fifo #(
    parameter int  DEPTH = 8,
    parameter int  W     = 18,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  logic [W-1:0]  i_wr_dat,
    input  logic          i_pop,
    output logic [W-1:0]  o_rd_dat,
    output logic          o_full,
    output logic          o_empty,
    output logic [LW-1:0] o_level
);
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic [W-1:0]  r_rd_dat;
    logic          w_push;
    logic          w_pop;

    assign o_full   = (r_level == LW'(DEPTH));
    assign o_empty  = (r_level == '0);
    assign o_level  = r_level;
    assign o_rd_dat = r_rd_dat;
    assign w_push   = i_push && !o_full;
    assign w_pop    = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_rd_dat <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_rd_dat <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and level.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wr_dat;
    end
endmodule

// File: rtl/iir_m_feeder.sv
// Feeds queued samples to a biquad filter one at a time: pop -> one-cycle start pulse -> wait for completion.
// Optional watchdog on the filter completion enabled by macro IIR_M_FEEDER_TIMEOUT_EN.
module iir_m_feeder
    import iir_m_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [SAMPLE_W-1:0] s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    output logic signed [SAMPLE_W-1:0] f_din,
    output logic                       f_din_valid,
    input  logic                       f_dout_valid,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       busy,
    output logic                       timeout_err
);
    if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < FILTER_LATENCY) begin : g_bad_cfg
        $error("iir_m_feeder: unsupported DEPTH or TIMEOUT");
    end

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic                w_timeout;
    logic [SAMPLE_W-1:0] w_rd_dat;

    assign s_ready     = rst && !w_full;
    assign w_push      = s_valid && s_ready;
    assign f_din       = w_rd_dat;
    assign f_din_valid = (r_state == ST_ISSUE);
    assign busy        = (r_state != ST_IDLE);

    // The FIFO read register doubles as the f_din holding register.
    iir_m_sync_fifo #(
        .DEPTH (DEPTH),
        .W     (SAMPLE_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .i_push   (w_push),
        .i_wr_dat (s_data),
        .i_pop    (w_pop),
        .o_rd_dat (w_rd_dat),
        .o_full   (w_full),
        .o_empty  (w_empty),
        .o_level  (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: w_state_nxt = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (f_dout_valid) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = ST_ISSUE;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

`ifdef IIR_M_FEEDER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_to_cnt;
    logic             r_timeout_err;

    // r_to_cnt holds the number of cycles elapsed since the ISSUE cycle.
    assign w_timeout   = (r_state == ST_WAIT_DONE) && (r_to_cnt == CNT_W'(TIMEOUT - 1));
    assign timeout_err = r_timeout_err;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == ST_ISSUE)          r_to_cnt <= CNT_W'(1);
            else if (r_state == ST_WAIT_DONE) r_to_cnt <= r_to_cnt + 1'b1;
            if (w_timeout && !f_dout_valid)   r_timeout_err <= 1'b1;
        end
    end
`else
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_iir_m_feeder.sv
// Scoreboard bench for iir_m_feeder: stimulus queues expected samples and issue cycles, a monitor checks each issue.
`timescale 1ns/1ps
module tb_iir_m_feeder;
    import iir_m_pkg::*;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 15;
    localparam int LVL_W   = $clog2(DEPTH) + 1;

    typedef struct {
        logic signed [SAMPLE_W-1:0] d;
        int                         t;
    } exp_t;

    logic                       clk;
    logic                       rst;
    logic signed [SAMPLE_W-1:0] s_data;
    logic                       s_valid;
    logic                       s_ready;
    logic signed [SAMPLE_W-1:0] f_din;
    logic                       f_din_valid;
    logic                       f_dout_valid;
    logic [LVL_W-1:0]           fifo_level;
    logic                       busy;
    logic                       timeout_err;

    exp_t                       sb[$];
    int                         due[$];
    int                         cyc = 0;
    int                         tests = 0;
    int                         fails = 0;
    int                         issue_cnt = 0;
    int                         last_issue = 0;
    int                         last_exp = -100;
    int                         held = 0;
    bit                         stall = 0;
    bit                         stray_req = 0;
    bit                         have_din = 0;
    logic signed [SAMPLE_W-1:0] cur_din;

    iir_m_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .f_din        (f_din),
        .f_din_valid  (f_din_valid),
        .f_dout_valid (f_dout_valid),
        .fifo_level   (fifo_level),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Filter model: answers FILTER_LATENCY-1 cycles after each start pulse unless stalled.
    initial begin
        f_dout_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            f_dout_valid = 1'b0;
            while (due.size() > 0 && due[0] < cyc) void'(due.pop_front());
            if (due.size() > 0 && due[0] == cyc) begin
                void'(due.pop_front());
                f_dout_valid = 1'b1;
            end
            if (stray_req) begin
                stray_req    = 1'b0;
                f_dout_valid = 1'b1;
            end
        end
    end

    // Monitor: every start pulse must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && f_din_valid) begin
                issue_cnt++;
                last_issue = cyc;
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL issue_unexpected: got f_din %0d at cycle %0d, expected no issue", f_din, cyc);
                end else begin
                    e = sb.pop_front();
                    if (f_din !== e.d) begin
                        fails++;
                        $display("FAIL issue_data: got %0d, expected %0d", f_din, e.d);
                    end
                    if (e.t >= 0) chk("issue_cycle", cyc, e.t);
                end
                cur_din  = f_din;
                have_din = 1'b1;
                if (stall) held++;
                else       due.push_back(cyc + FILTER_LATENCY - 1);
            end else if (rst && have_din) begin
                chk("din_stable", f_din, cur_din);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Issue time of a back-to-back stream: no earlier than accept+2, no closer than FILTER_LATENCY apart.
    task automatic push(input logic signed [SAMPLE_W-1:0] d, input bit timed);
        exp_t e;
        bit   ok;
        ok      = 1'b0;
        s_data  = d;
        s_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (s_ready) begin
                ok  = 1'b1;
                e.d = d;
                if (timed) begin
                    e.t      = (cyc + 2 > last_exp + FILTER_LATENCY) ? cyc + 2 : last_exp + FILTER_LATENCY;
                    last_exp = e.t;
                end else begin
                    e.t = -1;
                end
                sb.push_back(e);
            end
            step();
            if (ok) break;
        end
        s_valid = 1'b0;
        chk("push_accepted", ok, 1);
    endtask

    task automatic wait_issue(input int budget);
        int start;
        bit ok;
        start = issue_cnt;
        ok    = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (issue_cnt != start) begin
                ok = 1'b1;
                break;
            end
        end
        chk("issue_seen", ok, 1);
    endtask

    task automatic drain(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy && fifo_level == 0) ok = 1'b1;
            step();
            if (ok) break;
        end
        chk("drain_done", ok, 1);
        if (!ok) $display("FAIL drain_left: got %0d samples pending, expected 0", sb.size());
    endtask

    task automatic release_filter();
        stall = 1'b0;
        if (held > 0) begin
            due.push_back(cyc + 1);
            held = 0;
        end
    endtask

    initial begin
        logic [31:0] r;
        int          t;
        rst     = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        idle(3);

        @(negedge clk);
        chk("rst_level", fifo_level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_din_valid", f_din_valid, 0);
        chk("rst_din", f_din, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_s_ready", s_ready, 0);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("s_ready_after_rst", s_ready, 1);
        step();

        push(18'sd100, 1'b1);
        drain(100);

        for (int i = 1; i <= 5; i++) push(SAMPLE_W'(i), 1'b1);
        drain(200);
        @(negedge clk);
        chk("level_after_burst", fifo_level, 0);
        step();

        push(-18'sd32768, 1'b1);
        push(18'sd131071, 1'b1);
        push(-18'sd131072, 1'b1);
        drain(100);

        for (int i = 0; i < 40; i++) begin
            idle(($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 9));
            r = $urandom;
            push($signed(r[SAMPLE_W-1:0]), 1'b1);
        end
        drain(800);

        // Full FIFO behind a stalled filter.
        stall = 1'b1;
        push(-18'sd5, 1'b0);
        wait_issue(20);
        for (int i = 0; i < DEPTH; i++) push(SAMPLE_W'(1000 + i), 1'b0);
        @(negedge clk);
        chk("full_level", fifo_level, DEPTH);
        chk("full_s_ready", s_ready, 0);
        step();
        s_data  = 18'sd999;
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("full_hold_s_ready", s_ready, 0);
            step();
        end
        s_valid = 1'b0;
        @(negedge clk);
        chk("full_level_hold", fifo_level, DEPTH);
        step();
        release_filter();
        drain(300);
        last_exp = -100;

`ifdef IIR_M_FEEDER_TIMEOUT_EN
        stall = 1'b1;
        push(18'sd77, 1'b0);
        wait_issue(20);
        t = last_issue;
        while (cyc < t + TIMEOUT - 1) step();
        @(negedge clk);
        chk("to_err_before", timeout_err, 0);
        chk("to_busy_before", busy, 1);
        step();
        @(negedge clk);
        chk("to_err_at", timeout_err, 1);
        chk("to_busy_at", busy, 0);
        step();
        held  = 0;
        stall = 1'b0;
        push(18'sd78, 1'b1);
        drain(100);
        @(negedge clk);
        chk("to_err_sticky", timeout_err, 1);
        step();
`else
        stall = 1'b1;
        push(18'sd77, 1'b0);
        wait_issue(20);
        idle(40);
        @(negedge clk);
        chk("wait_forever_busy", busy, 1);
        chk("no_timeout_err", timeout_err, 0);
        step();
        release_filter();
        drain(100);
        t = last_issue;
`endif
        last_exp = -100;

        // Reset in WAIT_DONE with samples queued, then a stray completion pulse.
        for (int i = 0; i < 4; i++) push(SAMPLE_W'(200 + i), 1'b1);
        rst      = 1'b0;
        sb.delete();
        due.delete();
        held     = 0;
        have_din = 1'b0;
        @(negedge clk);
        chk("rst_mid_s_ready", s_ready, 0);
        step();
        @(negedge clk);
        chk("rst_mid_din", f_din, 0);
        chk("rst_mid_din_valid", f_din_valid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_level", fifo_level, 0);
        chk("rst_mid_timeout_err", timeout_err, 0);
        step();
        rst       = 1'b1;
        stray_req = 1'b1;
        idle(20);
        @(negedge clk);
        chk("stray_busy", busy, 0);
        chk("stray_level", fifo_level, 0);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        fails++;
        $display("FAIL watchdog: got no end of run by cycle %0d, expected completion", cyc);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end
endmodule
